// File: rtl/axi_wdata_proc.sv
// iDMA AXI write-data engine: FIFO beats -> W with WLAST/WSTRB, B tracking.
// Define AXI_WDATA_REG_SLICE_EN to drive W from a registered 2-entry skid buffer.
module axi_wdata_proc #(
    parameter int AXI_IDW      = 4,
    parameter int AXI_DATA_WID = 256,
    parameter int AXI_STRBW    = AXI_DATA_WID / 8,
    parameter int MAX_OUTSTD   = 8
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    wdata_fifo_empty_s,
    input  logic [AXI_DATA_WID-1:0] wdata_fifo_data_s,
    output logic                    wdata_fifo_pop,
    input  logic                    wcmd_valid,
    input  logic [7:0]              wcmd_len,
    input  logic                    wcmd_first_burst,
    input  logic                    wcmd_last_burst,
    output logic                    wcmd_ready,
    input  logic [5:0]              strb_first_beat_num,
    input  logic [5:0]              strb_last_beat_num,
    output logic [AXI_DATA_WID-1:0] o_wdata,
    output logic [AXI_STRBW-1:0]    o_wstrb,
    output logic                    o_wlast,
    output logic                    o_wvalid,
    input  logic                    i_wready,
    input  logic                    i_bvalid,
    input  logic [AXI_IDW-1:0]      i_bid,
    input  logic [1:0]              i_bresp,
    output logic                    o_bready,
    output logic                    axi_burst_wdata_ok,
    output logic                    dma_trans_wr_done,
    output logic                    bresp_err,
    input  logic                    bresp_err_clr
);

    // One spare bit: a burst may be in flight while MAX_OUTSTD are pending.
    localparam int CW = $clog2(MAX_OUTSTD) + 2;

    typedef enum logic {
        IDLE,
        DATA
    } state_t;

    state_t          state, state_nx;
    logic [7:0]      len_q, beat_cnt;
    logic            first_q, last_q;
    logic [5:0]      fnum_q, lnum_q;
    logic [CW-1:0]   outstd_cnt;
    logic            last_pend;

    logic                 core_valid, core_ready, core_last;
    logic                 core_hs, core_last_hs;
    logic [AXI_STRBW-1:0] core_strb;
    logic                 cmd_fire, wlast_hs, w_lastb, b_hs;
    logic                 unused_bid;

    assign unused_bid   = ^i_bid;
    assign core_valid   = (state == DATA) & ~wdata_fifo_empty_s;
    assign core_last    = (beat_cnt == len_q);
    assign core_hs      = core_valid & core_ready;
    assign core_last_hs = core_hs & core_last;

    assign wdata_fifo_pop = core_hs;
    assign wcmd_ready = aresetn & ((state == IDLE) | core_last_hs)
                      & (outstd_cnt < CW'(MAX_OUTSTD));
    assign cmd_fire   = wcmd_valid & wcmd_ready;

    always_comb begin
        for (int i = 0; i < AXI_STRBW; i++) begin
            core_strb[i] = 1'b1;
            if (first_q && beat_cnt == 8'd0 && i < int'(fnum_q))
                core_strb[i] = 1'b0;
            if (last_q && core_last && lnum_q != 6'd0 && i >= int'(lnum_q))
                core_strb[i] = 1'b0;
        end
    end

`ifdef AXI_WDATA_REG_SLICE_EN
    localparam int PW = AXI_DATA_WID + AXI_STRBW + 2;

    logic          out_v, skid_v;
    logic [PW-1:0] out_d, skid_d, core_d;

    assign core_d     = {last_q, core_last, core_strb, wdata_fifo_data_s};
    assign core_ready = ~skid_v;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            out_v  <= 1'b0;
            skid_v <= 1'b0;
            out_d  <= '0;
            skid_d <= '0;
        end else if (i_wready || !out_v) begin
            if (skid_v) begin
                out_d  <= skid_d;
                skid_v <= 1'b0;
            end else begin
                out_v <= core_hs;
                if (core_hs)
                    out_d <= core_d;
            end
        end else if (core_hs) begin
            skid_v <= 1'b1;
            skid_d <= core_d;
        end
    end

    assign o_wvalid = out_v;
    assign o_wdata  = out_d[AXI_DATA_WID-1:0];
    assign o_wstrb  = out_d[AXI_DATA_WID +: AXI_STRBW];
    assign o_wlast  = out_v & out_d[PW-2];
    assign w_lastb  = out_d[PW-1];
    assign wlast_hs = o_wvalid & i_wready & o_wlast;
`else
    assign core_ready = i_wready;
    assign o_wvalid   = core_valid;
    assign o_wdata    = wdata_fifo_data_s;
    assign o_wstrb    = core_valid ? core_strb : '0;
    assign o_wlast    = core_valid & core_last;
    assign w_lastb    = last_q;
    assign wlast_hs   = core_last_hs;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (cmd_fire) state_nx = DATA;
            DATA: if (core_last_hs && !cmd_fire) state_nx = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state <= IDLE;
        else          state <= state_nx;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            len_q    <= '0;
            beat_cnt <= '0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            fnum_q   <= '0;
            lnum_q   <= '0;
        end else if (cmd_fire) begin
            len_q    <= wcmd_len;
            beat_cnt <= '0;
            first_q  <= wcmd_first_burst;
            last_q   <= wcmd_last_burst;
            fnum_q   <= strb_first_beat_num;
            lnum_q   <= strb_last_beat_num;
        end else if (core_hs) begin
            beat_cnt <= beat_cnt + 8'd1;
        end
    end

    assign o_bready = (outstd_cnt != '0);
    assign b_hs     = i_bvalid & o_bready;
    // The final B only completes the transfer if no new WLAST refills the count.
    assign dma_trans_wr_done = b_hs & last_pend & ~wlast_hs
                             & (outstd_cnt == CW'(1));
    assign axi_burst_wdata_ok = wlast_hs;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            outstd_cnt <= '0;
            last_pend  <= 1'b0;
            bresp_err  <= 1'b0;
        end else begin
            case ({wlast_hs, b_hs})
                2'b10:   outstd_cnt <= outstd_cnt + CW'(1);
                2'b01:   outstd_cnt <= outstd_cnt - CW'(1);
                default: outstd_cnt <= outstd_cnt;
            endcase
            if (dma_trans_wr_done)
                last_pend <= 1'b0;
            else if (wlast_hs && w_lastb)
                last_pend <= 1'b1;
            if (bresp_err_clr)
                bresp_err <= 1'b0;
            else if (b_hs && i_bresp != 2'b00)
                bresp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axi_wdata_proc.sv
// Testbench for axi_wdata_proc: transaction-level model with per-cycle
// comparison, directed scenarios and a randomized soak.
module tb_axi_wdata_proc;

    localparam int DW   = 256;
    localparam int SW   = 32;
    localparam int IDW  = 4;
    localparam int MAXO = 8;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          wdata_fifo_empty_s = 1'b1;
    logic [DW-1:0] wdata_fifo_data_s = '0;
    logic          wdata_fifo_pop;
    logic          wcmd_valid = 1'b0;
    logic [7:0]    wcmd_len = '0;
    logic          wcmd_first_burst = 1'b0;
    logic          wcmd_last_burst = 1'b0;
    logic          wcmd_ready;
    logic [5:0]    strb_first_beat_num = '0;
    logic [5:0]    strb_last_beat_num = '0;
    logic [DW-1:0] o_wdata;
    logic [SW-1:0] o_wstrb;
    logic          o_wlast, o_wvalid;
    logic          i_wready = 1'b0;
    logic          i_bvalid = 1'b0;
    logic [IDW-1:0] i_bid = '0;
    logic [1:0]    i_bresp = '0;
    logic          o_bready;
    logic          axi_burst_wdata_ok, dma_trans_wr_done, bresp_err;
    logic          bresp_err_clr = 1'b0;

    always #5 aclk = ~aclk;

    axi_wdata_proc dut (
        .aclk(aclk), .aresetn(aresetn),
        .wdata_fifo_empty_s(wdata_fifo_empty_s),
        .wdata_fifo_data_s(wdata_fifo_data_s),
        .wdata_fifo_pop(wdata_fifo_pop),
        .wcmd_valid(wcmd_valid), .wcmd_len(wcmd_len),
        .wcmd_first_burst(wcmd_first_burst),
        .wcmd_last_burst(wcmd_last_burst),
        .wcmd_ready(wcmd_ready),
        .strb_first_beat_num(strb_first_beat_num),
        .strb_last_beat_num(strb_last_beat_num),
        .o_wdata(o_wdata), .o_wstrb(o_wstrb), .o_wlast(o_wlast),
        .o_wvalid(o_wvalid), .i_wready(i_wready),
        .i_bvalid(i_bvalid), .i_bid(i_bid), .i_bresp(i_bresp),
        .o_bready(o_bready),
        .axi_burst_wdata_ok(axi_burst_wdata_ok),
        .dma_trans_wr_done(dma_trans_wr_done),
        .bresp_err(bresp_err), .bresp_err_clr(bresp_err_clr)
    );

    typedef struct {
        int len;
        bit f;
        bit l;
        int fn;
        int ln;
    } cmd_t;

    cmd_t          cmdq[$];
    logic [DW-1:0] fifo[$];

    // Model: current burst, pending-B count, completion and error flags.
    bit   m_act;
    cmd_t m_cmd;
    int   m_beat;
    int   m_out;
    bit   m_pend;
    bit   m_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int p_wr = 100, p_push = 100, p_bv = 0, p_berr = 0, p_clr = 0;
    bit wr_toggle = 0, err_next = 0, fired = 0;
    int n_ok = 0, n_done = 0;
    logic [SW-1:0] strb_log[$];
    int            hs_cyc[$];

    bit            prev_stall = 0;
    logic [DW-1:0] prev_d;
    logic [SW-1:0] prev_s;
    logic          prev_l;

    task automatic chk(input string nm, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [SW-1:0] strb_of(input cmd_t c, input int beat);
        logic [63:0] s;
        s = '1;
        if (c.f && beat == 0)
            s &= ~((64'd1 << c.fn) - 64'd1);
        if (c.l && beat == c.len && c.ln != 0)
            s &= (64'd1 << c.ln) - 64'd1;
        return s[SW-1:0];
    endfunction

    task automatic cycle();
        bit exp_v, exp_l, w_hs, wl_hs, exp_rdy, exp_br, b_hs, exp_done;
        logic [SW-1:0] exp_s;
        cmd_t c;
        @(negedge aclk);
        cyc++;
        if (fired) begin
            wcmd_valid = 1'b0;
            fired = 0;
        end
        if (!wcmd_valid && cmdq.size() > 0 && (!cmdq[0].f || !m_act)) begin
            c = cmdq.pop_front();
            wcmd_valid = 1'b1;
            wcmd_len = 8'(c.len);
            wcmd_first_burst = c.f;
            wcmd_last_burst = c.l;
            strb_first_beat_num = 6'(c.fn);
            strb_last_beat_num = 6'(c.ln);
        end
        if (fifo.size() < 6 && $urandom_range(99) < p_push)
            fifo.push_back({8{$urandom()}});
        wdata_fifo_empty_s = (fifo.size() == 0);
        wdata_fifo_data_s = (fifo.size() > 0) ? fifo[0] : '0;
        i_wready = wr_toggle ? cyc[0] : ($urandom_range(99) < p_wr);
        i_bvalid = ($urandom_range(99) < p_bv);
        i_bresp = (err_next || $urandom_range(99) < p_berr) ? 2'd2 : 2'd0;
        i_bid = IDW'($urandom());
        bresp_err_clr = ($urandom_range(99) < p_clr);
        #1;
        exp_v = m_act && fifo.size() > 0;
        exp_l = exp_v && m_beat == m_cmd.len;
        exp_s = exp_v ? strb_of(m_cmd, m_beat) : '0;
        w_hs = exp_v && i_wready;
        wl_hs = w_hs && exp_l;
        exp_rdy = (!m_act || wl_hs) && m_out < MAXO;
        exp_br = (m_out != 0);
        b_hs = i_bvalid && exp_br;
        exp_done = b_hs && m_pend && m_out == 1 && !wl_hs;
        chk("wvalid", o_wvalid, exp_v);
        chk("wlast", o_wlast, exp_l);
        chk("wstrb", o_wstrb, exp_s);
        if (exp_v) chk("wdata", o_wdata, fifo[0]);
        chk("pop", wdata_fifo_pop, w_hs);
        chk("wcmd_ready", wcmd_ready, exp_rdy);
        chk("bready", o_bready, exp_br);
        chk("wdata_ok", axi_burst_wdata_ok, wl_hs);
        chk("wr_done", dma_trans_wr_done, exp_done);
        chk("bresp_err", bresp_err, m_err);
        if (prev_stall) begin
            chk("stall_valid", o_wvalid, 1'b1);
            chk("stall_data", o_wdata, prev_d);
            chk("stall_strb", o_wstrb, prev_s);
            chk("stall_last", o_wlast, prev_l);
        end
        prev_stall = o_wvalid && !i_wready;
        prev_d = o_wdata;
        prev_s = o_wstrb;
        prev_l = o_wlast;
        if (o_wvalid && i_wready) begin
            strb_log.push_back(o_wstrb);
            hs_cyc.push_back(cyc);
        end
        if (axi_burst_wdata_ok) n_ok++;
        if (dma_trans_wr_done) n_done++;
        if (w_hs) begin
            void'(fifo.pop_front());
            m_beat++;
        end
        if (wl_hs) begin
            m_out++;
            if (m_cmd.l) m_pend = 1;
            m_act = 0;
        end
        if (b_hs) begin
            m_out--;
            if (i_bresp != 0) err_next = 0;
        end
        if (exp_done) m_pend = 0;
        if (bresp_err_clr) m_err = 0;
        else if (b_hs && i_bresp != 0) m_err = 1;
        if (wcmd_valid && exp_rdy) begin
            m_act = 1;
            m_beat = 0;
            m_cmd.len = int'(wcmd_len);
            m_cmd.f = wcmd_first_burst;
            m_cmd.l = wcmd_last_burst;
            m_cmd.fn = int'(strb_first_beat_num);
            m_cmd.ln = int'(strb_last_beat_num);
            fired = 1;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic drain(input int limit, input bit need_b);
        int n = 0;
        while ((cmdq.size() > 0 || wcmd_valid || m_act ||
                (need_b && m_out != 0)) && n < limit) begin
            cycle();
            n++;
        end
        chk("drain_timeout", n < limit, 1'b1);
    endtask

    task automatic push_cmd(input int len, input bit f, input bit l,
                            input int fn, input int ln);
        cmd_t c;
        c.len = len; c.f = f; c.l = l; c.fn = fn; c.ln = ln;
        cmdq.push_back(c);
    endtask

    task automatic clear_logs();
        strb_log.delete();
        hs_cyc.delete();
        n_ok = 0;
        n_done = 0;
    endtask

    initial begin
        int nb, ln, fn, lnum;
        // Reset state
        repeat (2) @(negedge aclk);
        #1;
        chk("rst_wvalid", o_wvalid, 1'b0);
        chk("rst_wstrb", o_wstrb, '0);
        chk("rst_wcmd_ready", wcmd_ready, 1'b0);
        chk("rst_bready", o_bready, 1'b0);
        chk("rst_pop", wdata_fifo_pop, 1'b0);
        @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("post_rst_ready", wcmd_ready, 1'b1);

        // Four-beat single-burst transfer, FIFO full, B held back
        run(8);
        clear_logs();
        push_cmd(3, 1, 1, 4, 8);
        drain(100, 0);
        chk("t1_beats", strb_log.size(), 4);
        if (strb_log.size() == 4) begin
            chk("t1_strb0", strb_log[0], 32'hFFFFFFF0);
            chk("t1_strb1", strb_log[1], 32'hFFFFFFFF);
            chk("t1_strb2", strb_log[2], 32'hFFFFFFFF);
            chk("t1_strb3", strb_log[3], 32'h000000FF);
        end
        chk("t1_ok_pulses", n_ok, 1);
        p_bv = 100;
        drain(50, 1);
        chk("t1_done", n_done, 1);

        // Single-beat transfer
        clear_logs();
        push_cmd(0, 1, 1, 2, 6);
        drain(50, 1);
        chk("t2_beats", strb_log.size(), 1);
        if (strb_log.size() > 0) chk("t2_strb", strb_log[0], 32'h0000003C);
        chk("t2_done", n_done, 1);

        // Back-to-back bursts, no bubbles
        p_bv = 0;
        run(8);
        clear_logs();
        push_cmd(1, 1, 0, 0, 0);
        push_cmd(1, 0, 0, 0, 0);
        push_cmd(1, 0, 1, 0, 0);
        drain(100, 0);
        chk("t3_beats", hs_cyc.size(), 6);
        if (hs_cyc.size() == 6) chk("t3_span", hs_cyc[5] - hs_cyc[0], 5);
        chk("t3_ok_pulses", n_ok, 3);
        p_bv = 100;
        drain(50, 1);

        // Backpressure 1010 with the FIFO running dry mid-burst
        clear_logs();
        p_push = 0;
        wr_toggle = 1;
        push_cmd(7, 1, 1, 3, 5);
        run(16);
        p_push = 100;
        drain(200, 1);
        wr_toggle = 0;
        chk("t4_beats", strb_log.size(), 8);
        chk("t4_done", n_done, 1);

        // Outstanding limit with B withheld, then one error response
        clear_logs();
        p_bv = 0;
        for (int i = 0; i < 10; i++) push_cmd(0, i == 0, i == 9, 0, 0);
        run(40);
        chk("t5_ready_low", wcmd_ready, 1'b0);
        chk("t5_ok_ge8", n_ok >= 8, 1'b1);
        chk("t5_bready", o_bready, 1'b1);
        chk("t5_no_done_yet", n_done, 0);
        err_next = 1;
        p_bv = 100;
        drain(200, 1);
        chk("t5_bresp_err", bresp_err, 1'b1);
        chk("t5_done", n_done, 1);
        chk("t5_ok_all", n_ok, 10);
        p_clr = 100;
        run(1);
        p_clr = 0;
        run(1);
        chk("t5_err_clr", bresp_err, 1'b0);

        // Reset at beat 2 of 4 with a B pending
        p_bv = 0;
        push_cmd(0, 1, 0, 0, 0);
        push_cmd(3, 0, 1, 1, 1);
        nb = 0;
        while (!(m_act && m_cmd.len == 3 && m_beat == 2) && nb < 50) begin
            cycle();
            nb++;
        end
        chk("t6_reach_beat2", nb < 50, 1'b1);
        #2;
        aresetn = 1'b0;
        #1;
        chk("t6_wvalid", o_wvalid, 1'b0);
        chk("t6_wlast", o_wlast, 1'b0);
        chk("t6_bready", o_bready, 1'b0);
        chk("t6_wcmd_ready", wcmd_ready, 1'b0);
        chk("t6_pop", wdata_fifo_pop, 1'b0);
        m_act = 0; m_out = 0; m_pend = 0; m_err = 0;
        wcmd_valid = 1'b0; fired = 0; prev_stall = 0;
        cmdq.delete();
        repeat (2) @(negedge aclk);
        aresetn = 1'b1;
        #1;
        chk("t6_ready_after", wcmd_ready, 1'b1);
        chk("t6_bready_after", o_bready, 1'b0);
        clear_logs();
        p_bv = 100;
        push_cmd(3, 1, 1, 0, 0);
        drain(100, 1);
        chk("t6_beats", strb_log.size(), 4);
        chk("t6_done", n_done, 1);

        // Randomized soak
        p_wr = 70; p_push = 60; p_bv = 40; p_berr = 10; p_clr = 3;
        for (int t = 0; t < 60; t++) begin
            nb = $urandom_range(3, 1);
            fn = $urandom_range(31);
            lnum = $urandom_range(31);
            for (int b = 0; b < nb; b++) begin
                ln = $urandom_range(7);
                push_cmd(ln, b == 0, b == nb - 1, fn, lnum);
            end
        end
        drain(20000, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
